polaris_spi_flash_burst: RTL



---
 rtl/polaris_spi_flash_burst.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/polaris_spi_flash_burst.sv
// SPI-flash burst read controller on the LSI peripheral bus.
// One request in flight; reads pack 1-4 bytes little-endian into the response.
module polaris_spi_flash_burst #(
    parameter int         ADDR_BYTES = 3,
    parameter int         RD_BYTES   = 4,
    parameter logic [7:0] DIV_RST    = 8'd1,
    parameter logic [4:0] DUMMY_RST  = 5'd8,
    parameter logic       FAST_RST   = 1'b0
) (
    input  logic        lsioc_clk_i,
    input  logic        lsioc_rst_ni,
    input  logic        lsioc_rx_vld_i,
    input  logic [31:0] lsioc_rx_data_i,
    input  logic [2:0]  lsioc_rx_opc_i,
    output logic        lsioc_rx_busy_o,
    output logic [1:0]  lsioc_tx_err_code_o,
    output logic [31:0] lsioc_tx_data_o,
    output logic        lsioc_tx_vld_o,
    input  logic        lsioc_tx_busy_i,
    output logic        sck,
    output logic        mosi,
    output logic        cs_n,
    input  logic        miso
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, FINISH, RESP
    } state_t;

    localparam logic [5:0] ADDR_LAST = 6'(8 * ADDR_BYTES - 1);
    localparam logic [5:0] DATA_LAST = 6'(8 * RD_BYTES - 1);

    state_t      state;
    logic [7:0]  div_q;
    logic [4:0]  dummy_q;
    logic        fast_q;
    logic [2:0]  opc_q;
    logic [7:0]  hcnt;
    logic [5:0]  bcnt;
    logic [39:0] tx_sh;
    logic [31:0] rx_sh;
    logic [31:0] rd_word;
    logic [31:0] cfg_word;
    logic [31:0] addr_al;
    logic        tick;
    logic        last_bit;
    state_t      nxt_phase;

    assign lsioc_rx_busy_o = (state != IDLE);
    assign cfg_word = {15'b0, fast_q, 3'b0, dummy_q, div_q};
    assign tick     = (hcnt == div_q);
    // Address left-aligned so the shifter always emits from bit 39 down.
    assign addr_al  = 32'(lsioc_rx_data_i << (8 * (4 - ADDR_BYTES)));

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < RD_BYTES; k++) begin
            rd_word[8*k +: 8] = rx_sh[8*(RD_BYTES-1-k) +: 8];
        end
    end

    always_comb begin
        last_bit  = 1'b0;
        nxt_phase = state;
        unique case (state)
            CMD: begin
                last_bit  = (bcnt == 6'd7);
                nxt_phase = ADDR;
            end
            ADDR: begin
                last_bit  = (bcnt == ADDR_LAST);
                nxt_phase = (fast_q && dummy_q != 5'd0) ? DUMMY : DATA;
            end
            DUMMY: begin
                last_bit  = (bcnt == {1'b0, dummy_q} - 6'd1);
                nxt_phase = DATA;
            end
            DATA: begin
                last_bit  = (bcnt == DATA_LAST);
                nxt_phase = FINISH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge lsioc_clk_i) begin
        if (!lsioc_rst_ni) begin
            state               <= IDLE;
            div_q               <= DIV_RST;
            dummy_q             <= DUMMY_RST;
            fast_q              <= FAST_RST;
            opc_q               <= 3'b0;
            hcnt                <= 8'd0;
            bcnt                <= 6'd0;
            tx_sh               <= 40'd0;
            rx_sh               <= 32'd0;
            sck                 <= 1'b0;
            mosi                <= 1'b0;
            cs_n                <= 1'b1;
            lsioc_tx_vld_o      <= 1'b0;
            lsioc_tx_data_o     <= 32'd0;
            lsioc_tx_err_code_o <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lsioc_rx_vld_i) begin
                        opc_q <= lsioc_rx_opc_i;
                        if (lsioc_rx_opc_i == 3'b000) begin
                            state <= CMD;
                            tx_sh <= {fast_q ? 8'h0B : 8'h03, addr_al};
                        end else begin
                            state <= FINISH;
                            if (lsioc_rx_opc_i == 3'b001) begin
                                div_q   <= lsioc_rx_data_i[7:0];
                                dummy_q <= lsioc_rx_data_i[12:8];
                                fast_q  <= lsioc_rx_data_i[16];
                            end
                        end
                    end
                end
                CMD, ADDR, DUMMY, DATA: begin
                    if (cs_n) begin
                        cs_n <= 1'b0;
                        mosi <= tx_sh[39];
                        hcnt <= 8'd0;
                        bcnt <= 6'd0;
                    end else if (!tick) begin
                        hcnt <= hcnt + 8'd1;
                    end else begin
                        hcnt <= 8'd0;
                        sck  <= ~sck;
                        if (!sck) begin
                            if (state == DATA) rx_sh <= {rx_sh[30:0], miso};
                        end else begin
                            tx_sh <= tx_sh << 1;
                            mosi  <= tx_sh[38];
                            bcnt  <= bcnt + 6'd1;
                            if (last_bit) begin
                                bcnt  <= 6'd0;
                                state <= nxt_phase;
                            end
                        end
                    end
                end
                FINISH: begin
                    // cs_n still high means no SPI transfer: answer at once.
                    if (cs_n || tick) begin
                        state               <= RESP;
                        cs_n                <= 1'b1;
                        lsioc_tx_vld_o      <= 1'b1;
                        lsioc_tx_err_code_o <= (opc_q > 3'b010) ? 2'b01 : 2'b00;
                        if (opc_q == 3'b000)      lsioc_tx_data_o <= rd_word;
                        else if (opc_q == 3'b010) lsioc_tx_data_o <= cfg_word;
                        else                      lsioc_tx_data_o <= 32'd0;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                RESP: begin
                    if (!lsioc_tx_busy_i) begin
                        state          <= IDLE;
                        lsioc_tx_vld_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
